max7219_spi_tx: RTL
===================

Name: max7219_spi_tx

Overview:
Serial transmit stage that sits directly downstream of the MAX7219 settings/digit sequencer. It accepts one 4-bit register address and 8-bit data word per handshake. It serialises them as a 16-bit MAX7219 frame on CLK/DIN/LOAD and returns a one-cycle o_ack, which is wired to the sequencer's i_next. All SPI outputs are registered and glitch-free.

Parameters:
CLK_DIV, 4, system clocks per SPI half-period. Legal range 1..255. At 50 MHz the default gives 6.25 MHz SCLK.
HOLDOFF, 2, forced busy cycles after o_ack before a new request is accepted. Legal range 0..15. Gives upstream time to present the next addr/data.

Ports:
i_clk  input  1  system clock (~50 MHz)
i_reset_n  input  1  synchronous reset, active-low
i_stb  input  1  request, level. Upstream holds it high while it has a word pending.
i_addr  input  4  MAX7219 register address
i_data  input  8  MAX7219 register data
o_busy  output  1  high from the first cycle after accept through the end of HOLDOFF
o_ack  output  1  single-cycle pulse: frame latched into the device
o_spi_clk  output  1  MAX7219 CLK, idles low
o_spi_dout  output  1  MAX7219 DIN, MSB first
o_spi_cs_n  output  1  MAX7219 LOAD/CS, idles high

Behaviour:
- Clock and reset: i_clk; reset i_reset_n, synchronous, active-low.
- Reset values: o_busy=0, o_ack=0, o_spi_clk=0, o_spi_dout=0, o_spi_cs_n=1, state=IDLE, all counters 0.
- Frame format: word = {4'h0, i_addr, i_data}, 16 bits, sent bit 15 first.
- States: IDLE -> SHIFT -> TAIL -> LATCH -> HOLD -> IDLE.
- IDLE:
  - o_busy=0.
  - On a clock edge with i_stb=1, capture the word into the shift register and go to SHIFT.
  - i_addr/i_data are sampled only at this edge. Changes later in the frame are ignored.
- SHIFT (32*CLK_DIV cycles):
  - Entry: cs_n=0, clk=0, dout=bit15.
  - clk toggles every CLK_DIV cycles: low phase first, then high phase, per bit.
  - dout changes only on the clk high->low transition, i.e. at the start of the next bit's low phase. Data is therefore stable across each rising edge.
  - After the 16th high phase completes, clk returns low and the state goes to TAIL.
  - Exactly 16 rising edges per frame.
- TAIL (CLK_DIV cycles): clk=0, cs_n=0, dout=0.
- LATCH (CLK_DIV cycles):
  - cs_n=1; its rising edge latches the frame in the device.
  - o_ack=1 on the last LATCH cycle only.
- HOLD (HOLDOFF cycles, skipped if 0): cs_n=1, o_busy=1.
- Timing per frame: o_busy is high for 34*CLK_DIV+HOLDOFF consecutive cycles, and o_ack fires in busy cycle 34*CLK_DIV.
- Back-to-back: after HOLD the block spends exactly 1 cycle in IDLE (o_busy=0). If i_stb is still high, the next word is captured in that cycle.
- Counters: the half-period counter is ceil(log2(CLK_DIV)) bits (minimum 1); the bit counter is 4 bits.
  - No wrap: the bit counter terminates at the 16th rising edge.
  - CLK_DIV=1 must work (SCLK = i_clk/2).
- o_ack is never asserted while in IDLE. i_stb arriving during busy is ignored and is not queued.
- Reset mid-frame: next cycle all outputs return to reset values. No o_ack is produced.
  - cs_n rising during reset latches a partial word in the device; upstream is responsible for re-sending the config after reset.

Test Plan:
- CLK_DIV=4, HOLDOFF=2, single frame addr=4'hA data=8'h05, i_stb dropped after ack -> bits sampled at the 16 clk rising edges = 16'h0A05. cs_n low 132 cycles. o_ack is one pulse in busy cycle 136. o_busy high 138 cycles, then stays idle.
- i_stb held high with words 16'h0901 then 16'h0B07 (upstream switches on ack) -> second frame starts after exactly 1 idle cycle. The decoded words are 0x0901 and 0x0B07, and each frame has exactly 16 rising edges.
- Change i_addr/i_data to 4'hF/8'hFF at bit 5 of a frame carrying 4'hC/8'h01 -> shifted word is still 16'h0C01.
- i_reset_n low for 1 cycle at bit 7 -> next cycle cs_n=1, clk=0, dout=0, busy=0. No o_ack, and no rising clk edges follow.
- CLK_DIV=1, HOLDOFF=0 -> clk period is 2 cycles, o_busy is high 34 cycles, o_ack is in busy cycle 34, and the word decodes correctly.
- Reset held with i_stb=1 -> all outputs stay at reset values. The first frame starts on the first cycle after reset release.

Source files
------------

// File: rtl/max7219_spi_tx.sv
// MAX7219 serial transmit stage.
// Takes one {addr, data} pair per handshake and shifts it out as a 16-bit
// frame on CLK/DIN/LOAD. The frame is sent MSB first. When LOAD has risen,
// the block returns a one-cycle o_ack to the upstream sequencer.
module max7219_spi_tx #(
  parameter int CLK_DIV = 4,
  parameter int HOLDOFF = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_stb,
  input  logic [3:0] i_addr,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic       o_ack,
  output logic       o_spi_clk,
  output logic       o_spi_dout,
  output logic       o_spi_cs_n
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  // The LATCH phase uses this to raise o_ack one cycle early, so that the
  // registered pulse falls on the final LATCH cycle.
  localparam logic [DIV_W-1:0] DIV_PENULT = DIV_W'(CLK_DIV - 2);
  localparam logic [3:0]       HOLD_LAST  = 4'(HOLDOFF - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    TAIL,
    LATCH,
    HOLD
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       bit_cnt;
  logic [3:0]       hold_cnt;
  // Holds the 15 bits still to send. Bit 15 of the frame goes straight to DIN.
  logic [14:0]      shreg;

  // Frame sequencer. Every SPI output is a register, so the pins cannot glitch.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      hold_cnt   <= '0;
      shreg      <= '0;
      o_busy     <= 1'b0;
      o_ack      <= 1'b0;
      o_spi_clk  <= 1'b0;
      o_spi_dout <= 1'b0;
      o_spi_cs_n <= 1'b1;
    end else begin
      o_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (i_stb) begin
            shreg      <= {3'b000, i_addr, i_data};
            o_spi_dout <= 1'b0;
            o_spi_clk  <= 1'b0;
            o_spi_cs_n <= 1'b0;
            o_busy     <= 1'b1;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            state      <= SHIFT;
          end
        end

        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!o_spi_clk) begin
              o_spi_clk <= 1'b1;
            end else begin
              o_spi_clk <= 1'b0;
              if (bit_cnt == 4'd15) begin
                o_spi_dout <= 1'b0;
                state      <= TAIL;
              end else begin
                bit_cnt    <= bit_cnt + 4'd1;
                o_spi_dout <= shreg[14];
                shreg      <= {shreg[13:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        TAIL: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt    <= '0;
            o_spi_cs_n <= 1'b1;
            o_ack      <= (CLK_DIV == 1);
            state      <= LATCH;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        LATCH: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (HOLDOFF == 0) begin
              o_busy <= 1'b0;
              state  <= IDLE;
            end else begin
              hold_cnt <= '0;
              state    <= HOLD;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
            o_ack   <= (div_cnt == DIV_PENULT);
          end
        end

        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
